// File: rtl/fpnew_result_reorder.sv
// In-order result reorder buffer: tags dispatched ops, absorbs out-of-order results, retires in issue order.
// Optional protocol checking (sticky err_o) is compiled in with FPNEW_REORDER_CHECK_EN.

package fpnew_pkg;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;
endpackage

module fpnew_result_reorder #(
  parameter int unsigned Width   = 32,
  parameter int unsigned NumTags = 4,
  localparam int unsigned TagBits = $clog2(NumTags)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [TagBits-1:0]   tag_o,
  input  logic                 res_valid_i,
  output logic                 res_ready_o,
  input  logic [TagBits-1:0]   res_tag_i,
  input  logic [Width-1:0]     res_result_i,
  input  fpnew_pkg::status_t   res_status_i,
  input  logic                 res_ext_bit_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [Width-1:0]     result_o,
  output fpnew_pkg::status_t   status_o,
  output logic                 extension_bit_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned CntBits = TagBits + 1;

  typedef enum logic [1:0] {
    ENT_FREE,
    ENT_PENDING,
    ENT_DONE
  } entry_state_e;

  entry_state_e        state_q [NumTags];
  entry_state_e        state_d [NumTags];
  logic [Width-1:0]    result_q [NumTags];
  fpnew_pkg::status_t  status_q [NumTags];
  logic                ext_q    [NumTags];

  logic [TagBits-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [TagBits-1:0]  retire_ptr_q, retire_ptr_d;
  logic [CntBits-1:0]  count_q, count_d;

  logic accept_c, retire_c, write_ok_c;

  // Status outputs are decoded directly from registered state.
  assign in_ready_o      = (count_q < CntBits'(NumTags));
  assign tag_o           = alloc_ptr_q;
  assign res_ready_o     = 1'b1;
  assign out_valid_o     = (state_q[retire_ptr_q] == ENT_DONE);
  assign result_o        = result_q[retire_ptr_q];
  assign status_o        = status_q[retire_ptr_q];
  assign extension_bit_o = ext_q[retire_ptr_q];
  assign busy_o          = (count_q != '0);

  assign accept_c   = in_valid_i && in_ready_o;
  assign retire_c   = out_valid_o && out_ready_i;
  assign write_ok_c = res_valid_i && (state_q[res_tag_i] == ENT_PENDING);

  // Entry states never collide: alloc hits FREE, write hits PENDING, retire hits DONE.
  always_comb begin
    state_d      = state_q;
    alloc_ptr_d  = alloc_ptr_q;
    retire_ptr_d = retire_ptr_q;
    count_d      = count_q;

    if (write_ok_c) state_d[res_tag_i] = ENT_DONE;
    if (accept_c) begin
      state_d[alloc_ptr_q] = ENT_PENDING;
      alloc_ptr_d          = alloc_ptr_q + TagBits'(1);
    end
    if (retire_c) begin
      state_d[retire_ptr_q] = ENT_FREE;
      retire_ptr_d          = retire_ptr_q + TagBits'(1);
    end

    unique case ({accept_c, retire_c})
      2'b10:   count_d = count_q + CntBits'(1);
      2'b01:   count_d = count_q - CntBits'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      state_d      = '{default: ENT_FREE};
      alloc_ptr_d  = '0;
      retire_ptr_d = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= '{default: ENT_FREE};
      alloc_ptr_q  <= '0;
      retire_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      alloc_ptr_q  <= alloc_ptr_d;
      retire_ptr_q <= retire_ptr_d;
      count_q      <= count_d;
    end
  end

  // Payload storage carries no reset; it is only observed once its entry is DONE.
  always_ff @(posedge clk_i) begin
    if (write_ok_c && !flush_i && !rst_i) begin
      result_q[res_tag_i] <= res_result_i;
      status_q[res_tag_i] <= res_status_i;
      ext_q[res_tag_i]    <= res_ext_bit_i;
    end
  end

`ifdef FPNEW_REORDER_CHECK_EN
  logic               err_q;
  logic               hold_q;
  logic [Width-1:0]   hold_result_q;
  fpnew_pkg::status_t hold_status_q;
  logic               hold_ext_q;
  logic               bad_write_c, unstable_c;

  assign bad_write_c = res_valid_i && !flush_i && (state_q[res_tag_i] != ENT_PENDING);
  // A stalled head must stay valid with identical payload on the following cycle.
  assign unstable_c  = hold_q && (!out_valid_o || (result_o != hold_result_q) ||
                                  (status_o != hold_status_q) || (extension_bit_o != hold_ext_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q         <= 1'b0;
      hold_q        <= 1'b0;
      hold_result_q <= '0;
      hold_status_q <= '0;
      hold_ext_q    <= 1'b0;
    end else begin
      if (bad_write_c || unstable_c) err_q <= 1'b1;
      hold_q        <= out_valid_o && !out_ready_i && !flush_i;
      hold_result_q <= result_o;
      hold_status_q <= status_o;
      hold_ext_q    <= extension_bit_o;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpnew_result_reorder.sv
// Directed bench for fpnew_result_reorder: vector table plus streaming, backpressure and reset sequences.
// Honours FPNEW_REORDER_CHECK_EN to decide whether err_o is expected to latch.

module tb_fpnew_result_reorder;

`ifdef FPNEW_REORDER_CHECK_EN
  localparam logic Check = 1'b1;
`else
  localparam logic Check = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_i, flush_i, in_valid_i, res_valid_i, out_ready_i, res_ext_bit_i;
  logic [1:0]         res_tag_i;
  logic [31:0]        res_result_i;
  fpnew_pkg::status_t res_status_i;
  logic               in_ready_o, res_ready_o, out_valid_o, extension_bit_o, busy_o, err_o;
  logic [1:0]         tag_o;
  logic [31:0]        result_o;
  fpnew_pkg::status_t status_o;
  logic [4:0]         st_bits;

  assign st_bits = status_o;

  always #5 clk = ~clk;

  fpnew_result_reorder #(.Width(32), .NumTags(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .tag_o(tag_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_tag_i(res_tag_i),
    .res_result_i(res_result_i), .res_status_i(res_status_i), .res_ext_bit_i(res_ext_bit_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o),
    .status_o(status_o), .extension_bit_o(extension_bit_o), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic        iv;
    logic        rv;
    logic [1:0]  rt;
    logic [31:0] rr;
    logic        ordy;
    logic        fl;
    logic        e_rdy;
    logic [1:0]  e_tag;
    logic        e_ov;
    logic [31:0] e_res;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  localparam int NVec = 26;
  vec_t vt [NVec];
  int applied = 0;
  int miscompares = 0;

  function automatic vec_t mk(input int iv, rv, rt, rr, ordy, fl,
                              input int e_rdy, e_tag, e_ov, e_res, e_busy, input logic e_err);
    vec_t v;
    v.iv = 1'(iv); v.rv = 1'(rv); v.rt = 2'(rt); v.rr = 32'(rr);
    v.ordy = 1'(ordy); v.fl = 1'(fl);
    v.e_rdy = 1'(e_rdy); v.e_tag = 2'(e_tag); v.e_ov = 1'(e_ov);
    v.e_res = 32'(e_res); v.e_busy = 1'(e_busy); v.e_err = e_err;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; in_valid_i = 0; res_valid_i = 0; res_tag_i = 0;
    res_result_i = 0; res_status_i = '0; res_ext_bit_i = 0; out_ready_i = 0;
  endtask

  task automatic check(input string nm, input logic e_rdy, input logic [1:0] e_tag,
                       input logic e_ov, input logic [31:0] e_res, input logic [4:0] e_st,
                       input logic e_ext, input logic e_busy, input logic e_err);
    logic bad;
    bad = (in_ready_o !== e_rdy) || (tag_o !== e_tag) || (out_valid_o !== e_ov) ||
          (busy_o !== e_busy) || (err_o !== e_err) || (res_ready_o !== 1'b1);
    if (e_ov)
      bad = bad || (result_o !== e_res) || (st_bits !== e_st) || (extension_bit_o !== e_ext);
    applied++;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got rdy=%b tag=%0d ov=%b res=%h st=%b ext=%b busy=%b err=%b resrdy=%b; want rdy=%b tag=%0d ov=%b res=%h st=%b ext=%b busy=%b err=%b resrdy=1",
               nm, in_ready_o, tag_o, out_valid_o, result_o, st_bits, extension_bit_o, busy_o, err_o,
               res_ready_o, e_rdy, e_tag, e_ov, e_res, e_st, e_ext, e_busy, e_err);
    end
  endtask

  initial begin
    //            iv rv rt rr     ordy fl  rdy tag ov res    busy err
    vt[0]  = mk(1, 0, 0, 0,     1, 0,  1, 0, 0, 0,     0, 1'b0);
    vt[1]  = mk(1, 0, 0, 0,     1, 0,  1, 1, 0, 0,     1, 1'b0);
    vt[2]  = mk(1, 0, 0, 0,     1, 0,  1, 2, 0, 0,     1, 1'b0);
    vt[3]  = mk(1, 0, 0, 0,     1, 0,  1, 3, 0, 0,     1, 1'b0);
    vt[4]  = mk(0, 1, 2, 'h12,  1, 0,  0, 0, 0, 0,     1, 1'b0);
    vt[5]  = mk(0, 1, 0, 'h10,  1, 0,  0, 0, 0, 0,     1, 1'b0);
    vt[6]  = mk(0, 1, 3, 'h13,  1, 0,  0, 0, 1, 'h10,  1, 1'b0);
    vt[7]  = mk(0, 1, 1, 'h11,  1, 0,  1, 0, 0, 0,     1, 1'b0);
    vt[8]  = mk(0, 0, 0, 0,     1, 0,  1, 0, 1, 'h11,  1, 1'b0);
    vt[9]  = mk(0, 0, 0, 0,     1, 0,  1, 0, 1, 'h12,  1, 1'b0);
    vt[10] = mk(0, 0, 0, 0,     1, 0,  1, 0, 1, 'h13,  1, 1'b0);
    vt[11] = mk(0, 0, 0, 0,     1, 0,  1, 0, 0, 0,     0, 1'b0);
    vt[12] = mk(1, 0, 0, 0,     1, 0,  1, 0, 0, 0,     0, 1'b0);
    vt[13] = mk(1, 0, 0, 0,     1, 0,  1, 1, 0, 0,     1, 1'b0);
    vt[14] = mk(1, 0, 0, 0,     1, 0,  1, 2, 0, 0,     1, 1'b0);
    vt[15] = mk(1, 0, 0, 0,     1, 0,  1, 3, 0, 0,     1, 1'b0);
    vt[16] = mk(1, 1, 0, 'h20,  1, 0,  0, 0, 0, 0,     1, 1'b0);
    vt[17] = mk(0, 0, 0, 0,     1, 0,  0, 0, 1, 'h20,  1, 1'b0);
    vt[18] = mk(1, 0, 0, 0,     1, 0,  1, 0, 0, 0,     1, 1'b0);
    vt[19] = mk(0, 0, 0, 0,     1, 0,  0, 1, 0, 0,     1, 1'b0);
    vt[20] = mk(0, 1, 2, 'h22,  1, 0,  0, 1, 0, 0,     1, 1'b0);
    vt[21] = mk(0, 1, 3, 'h33,  1, 1,  0, 1, 0, 0,     1, 1'b0);
    vt[22] = mk(1, 1, 1, 'h44,  1, 0,  1, 0, 0, 0,     0, 1'b0);
    vt[23] = mk(0, 1, 0, 'h50,  1, 0,  1, 1, 0, 0,     1, Check);
    vt[24] = mk(0, 0, 0, 0,     1, 0,  1, 1, 1, 'h50,  1, Check);
    vt[25] = mk(0, 0, 0, 0,     1, 0,  1, 1, 0, 0,     0, Check);

    idle();
    rst_i = 1;
    tick();
    tick();
    rst_i = 0;
    check("reset_state", 1, 0, 0, 0, 0, 0, 0, 0);

    // Outputs are checked against the state left by the previous edge, then the edge is taken.
    for (int i = 0; i < NVec; i++) begin
      in_valid_i = vt[i].iv; res_valid_i = vt[i].rv; res_tag_i = vt[i].rt;
      res_result_i = vt[i].rr; out_ready_i = vt[i].ordy; flush_i = vt[i].fl;
      res_status_i = '0; res_ext_bit_i = 0;
      check($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_tag, vt[i].e_ov, vt[i].e_res,
            5'b0, 1'b0, vt[i].e_busy, vt[i].e_err);
      tick();
    end
    idle();

    // Streaming: alloc pointer starts at 1 after the table; results return one cycle after issue.
    for (int c = 0; c < 20; c++) begin
      in_valid_i = 1; out_ready_i = 1;
      res_valid_i = (c > 0);
      res_tag_i = 2'(c);
      res_result_i = 32'('h100 + c - 1);
      check($sformatf("stream%0d", c), 1, 2'(1 + c), (c >= 2), 32'('h100 + c - 2),
            5'b0, 1'b0, (c > 0), Check);
      tick();
    end
    in_valid_i = 0; res_valid_i = 1; res_tag_i = 2'(20); res_result_i = 32'h113;
    check("stream_drain0", 1, 1, 1, 32'h112, 5'b0, 0, 1, Check);
    tick();
    res_valid_i = 0;
    check("stream_drain1", 1, 1, 1, 32'h113, 5'b0, 0, 1, Check);
    tick();
    check("stream_empty", 1, 1, 0, 0, 5'b0, 0, 0, Check);

    // Backpressure: head held DONE with out_ready low must stay valid and stable.
    idle();
    in_valid_i = 1;
    tick();
    in_valid_i = 0; res_valid_i = 1; res_tag_i = 1; res_result_i = 32'hCAFE;
    res_status_i = 5'b10101; res_ext_bit_i = 1;
    tick();
    idle();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d", c), 1, 2, 1, 32'hCAFE, 5'b10101, 1, 1, Check);
      tick();
    end
    out_ready_i = 1;
    check("hold_release", 1, 2, 1, 32'hCAFE, 5'b10101, 1, 1, Check);
    tick();
    out_ready_i = 0;
    check("hold_drained", 1, 2, 0, 0, 5'b0, 0, 0, Check);

    // Mid-stream reset after a stray write to a FREE entry.
    in_valid_i = 1;
    tick();
    tick();
    in_valid_i = 0; res_valid_i = 1; res_tag_i = 0; res_result_i = 32'hDEAD;
    tick();
    idle();
    check("pre_reset", 1, 0, 0, 0, 5'b0, 0, 1, Check);
    rst_i = 1; in_valid_i = 1; out_ready_i = 1;
    tick();
    rst_i = 0; idle();
    check("mid_reset", 1, 0, 0, 0, 5'b0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/fpnew_result_reorder.md
# fpnew_result_reorder

Issue-side companion to the operation-group blocks. It allocates a tag for every operation dispatched into an opgroup block, and accepts results returned in arbitrary order by that block's round-robin output arbiter. Results are released to the writeback in strict issue order. It sits between the FPU's operation dispatch and its result/writeback port.

## Interface
Parameters:
- Width, 32, result width in bits.
- NumTags, 4, number of in-flight operations; power of two, at least 2.
- TagBits (localparam), $clog2(NumTags), tag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- flush_i  in  1  discard all in-flight state.
- in_valid_i  in  1  dispatch requests a tag.
- in_ready_o  out  1  tag available.
- tag_o  out  TagBits  tag allocated on an in_valid_i & in_ready_o cycle.
- res_valid_i  in  1  result returned from the opgroup block.
- res_ready_o  out  1  constant 1; a slot is always reserved.
- res_tag_i  in  TagBits  tag of the returned result.
- res_result_i  in  Width  result data.
- res_status_i  in  fpnew_pkg::status_t  exception flags.
- res_ext_bit_i  in  1  extension bit.
- out_valid_o  out  1  in-order result available.
- out_ready_i  in  1  writeback accepts.
- result_o  out  Width  retired result.
- status_o  out  fpnew_pkg::status_t  retired flags.
- extension_bit_o  out  1  retired extension bit.
- busy_o  out  1  any entry not FREE.
- err_o  out  1  sticky protocol error (see Configuration).

## Operation
- Storage: circular buffer of NumTags entries. Each entry holds a state (FREE, PENDING or DONE), the result, the status and the extension bit.
- Pointers:
  - alloc_ptr and retire_ptr are TagBits wide and wrap modulo NumTags.
  - count is TagBits+1 wide, range 0..NumTags.
- Allocate:
  - in_ready_o = (count < NumTags).
  - tag_o = alloc_ptr.
  - On accept: entry[alloc_ptr] FREE→PENDING and alloc_ptr+1.
- Result write:
  - If res_valid_i and entry[res_tag_i] is PENDING: store the data and move the entry PENDING→DONE.
  - A write to a FREE or DONE entry is ignored and sets err_o (when checking is compiled in).
- Retire:
  - out_valid_o = (entry[retire_ptr] is DONE).
  - result_o, status_o and extension_bit_o are read from entry[retire_ptr].
  - On out_valid_o & out_ready_i: entry DONE→FREE and retire_ptr+1.
- count: +1 on accept, −1 on retire, unchanged when both happen in the same cycle.
- Outputs: in_ready_o does not depend on out_ready_i, so there is no full-bypass path. Data outputs are don't-care while out_valid_o=0.
- Flush and reset:
  - Every entry goes to FREE; pointers and count go to 0.
  - A result, allocation or retire presented in the same cycle is dropped.
  - err_o is cleared by reset only, not by flush.
- Reset values: in_ready_o=1, tag_o=0, out_valid_o=0, busy_o=0, err_o=0, res_ready_o=1.

## Timing
- Result-to-output latency is 1 cycle. A result written to the head entry in cycle N gives out_valid_o in cycle N+1; there is no same-cycle bypass.
- A full buffer whose head retires in cycle N asserts in_ready_o in cycle N+1.
- Simultaneous events:
  - Allocate + retire in the same cycle is legal when count < NumTags.
  - A result write to entry k in the same cycle as retiring entry j≠k is legal.
  - Writing the entry being retired is impossible, because that entry is DONE and the write is flagged.
- Back-to-back: with out_ready_i=1 and results returned in order, throughput is one operation per cycle.
- out_valid_o, once asserted, stays high with stable data until accepted or flushed.

## Configuration
- Macro: FPNEW_REORDER_CHECK_EN.
- Defined:
  - err_o is set the cycle after a res_valid_i to a non-PENDING tag, and holds until reset.
  - err_o is also set on out_ready_i=0 violations of the stability rule; this is an internal assertion only, with no behavioural change.
- Undefined:
  - err_o is tied to 0 and there is no checking logic.
  - Writes to non-PENDING entries are still ignored.

## Test plan
- Issue 4 ops (tags 0,1,2,3, NumTags=4), return results in order 2,0,3,1 with result=tag+0x10. Required:
  - out_valid_o first rises the cycle after tag 0 returns.
  - Outputs are 0x10, 0x11, 0x12, 0x13, in order.
- Fill to 4 → in_ready_o=0. Return and retire tag 0 → in_ready_o=1 the next cycle, and the next allocation gets tag 0 (wrap-around).
- Streaming: in_valid_i=1, immediate in-order results, out_ready_i=1 for 20 cycles. Required: one retire per cycle, count stays ≤2, tag_o cycles 0..3.
- Backpressure: hold out_ready_i=0 for 5 cycles with the head DONE. Required: result_o/status_o stable and out_valid_o held; then retire on release.
- Flush with 3 PENDING and 1 DONE, plus a result arriving in the flush cycle. Required:
  - Next cycle: busy_o=0, out_valid_o=0, tag_o=0.
  - The late result is not emitted.
  - After flush, a result to tag 1 sets err_o when FPNEW_REORDER_CHECK_EN is defined, and leaves err_o=0 when it is undefined.
- Assert rst_i mid-stream for 1 cycle. Required: all outputs at their reset values the next cycle, and err_o cleared.
